// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped programmable down-counter with one-shot/auto-reload modes
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT; irq drives one processor HWInt bit.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_ctrl;
    logic [3:0]       w_ctrl_next;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] w_preset_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_irq_flag;
    logic             w_irq_flag_next;

    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_auto;
    logic             w_set;
    logic [31:0]      w_preset_ext;
    logic [31:0]      w_preset_merged;
    logic             w_unused;

    assign hit          = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr         = hit && (byteen != 4'b0000);
    assign w_wr_ctrl    = w_wr && (addr[3:2] == 2'b00) && byteen[0];
    assign w_wr_preset  = w_wr && (addr[3:2] == 2'b01);
    assign w_auto       = (r_ctrl[2:1] == 2'b01);
    assign w_preset_ext = 32'(r_preset);
    assign w_unused     = ^addr[1:0];

    // Terminal count reached this edge: the flag set must beat a same-edge CTRL clear.
    assign w_set = (r_state == CNT) && r_ctrl[0] && (r_count == '0);

    always_comb begin
        w_preset_merged = w_preset_ext;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                w_preset_merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ctrl_next     = r_ctrl;
        w_count_next    = r_count;
        w_irq_flag_next = r_irq_flag;
        w_preset_next   = w_wr_preset ? CNT_W'(w_preset_merged) : r_preset;

        case (r_state)
            IDLE: begin
                if (r_ctrl[0]) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (!r_ctrl[0]) begin
                    w_state_next = IDLE;
                end else begin
                    w_count_next = r_preset;
                    w_state_next = CNT;
                end
            end
            CNT: begin
                if (!r_ctrl[0]) begin
                    w_state_next = IDLE;
                end else if (r_count == '0) begin
                    w_state_next    = INT;
                    w_irq_flag_next = 1'b1;
                end else begin
                    w_count_next = r_count - CNT_W'(1);
                end
            end
            INT: begin
                if (w_auto) begin
                    w_irq_flag_next = 1'b0;
                    w_state_next    = LOAD;
                end else begin
                    w_ctrl_next[0] = 1'b0;
                    w_state_next   = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Bus writes override the one-shot EN clear.
        if (w_wr_ctrl) begin
            w_ctrl_next = wdata[3:0];
            if (!w_set) begin
                w_irq_flag_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ctrl     <= 4'b0000;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
            irq        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ctrl     <= w_ctrl_next;
            r_preset   <= w_preset_next;
            r_count    <= w_count_next;
            r_irq_flag <= w_irq_flag_next;
            irq        <= w_ctrl_next[3] & w_irq_flag_next;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (addr[3:2])
                2'b00:   rdata = {28'h0, r_ctrl};
                2'b01:   rdata = 32'(r_preset);
                2'b10:   rdata = 32'(r_count);
                default: rdata = 32'h0;
            endcase
        end
    end

endmodule
